// File: rtl/node_exec_ctrl_pkg.sv
// Shared codes for the node execution sequencer: opcodes, location codes,
// neighbour direction indices, FSM states and small decode helpers.
package node_exec_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_SWP = 4'd2;
    localparam logic [3:0] OP_SAV = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JEZ = 4'd8;
    localparam logic [3:0] OP_JNZ = 4'd9;
    localparam logic [3:0] OP_JGZ = 4'd10;
    localparam logic [3:0] OP_JLZ = 4'd11;
    localparam logic [3:0] OP_JRO = 4'd12;

    localparam logic [2:0] LOC_NIL   = 3'd0;
    localparam logic [2:0] LOC_ACC   = 3'd1;
    localparam logic [2:0] LOC_UP    = 3'd2;
    localparam logic [2:0] LOC_DOWN  = 3'd3;
    localparam logic [2:0] LOC_LEFT  = 3'd4;
    localparam logic [2:0] LOC_RIGHT = 3'd5;
    localparam logic [2:0] LOC_IMM   = 3'd6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_EXEC  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } exec_state_e;

    function automatic logic loc_is_port(input logic [2:0] loc);
        return (loc == LOC_UP) || (loc == LOC_DOWN) || (loc == LOC_LEFT) || (loc == LOC_RIGHT);
    endfunction

    // Port locations are contiguous, so the direction index is an offset from LOC_UP.
    function automatic logic [1:0] loc_dir(input logic [2:0] loc);
        logic [2:0] off;
        off = loc - LOC_UP;
        return off[1:0];
    endfunction

    function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
        return 4'b0001 << dir;
    endfunction

    function automatic logic op_reads_port(input logic [3:0] op, input logic [2:0] src);
        return ((op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_JRO))
               && loc_is_port(src);
    endfunction

    function automatic logic op_writes_port(input logic [3:0] op, input logic [2:0] dst);
        return (op == OP_MOV) && loc_is_port(dst);
    endfunction

endpackage

// File: rtl/node_exec_ctrl_if.sv
// Neighbour-port handshake bundle: four read lanes and one shared write bus.
interface node_exec_ctrl_if #(parameter int DATA_W = 11);
    logic [3:0]          rd_valid;
    logic [4*DATA_W-1:0] rd_data;
    logic [3:0]          wr_ready;
    logic [3:0]          rd_req;
    logic [3:0]          wr_valid;
    logic [DATA_W-1:0]   wr_data;

    modport master (
        input  rd_valid, rd_data, wr_ready,
        output rd_req, wr_valid, wr_data
    );

    modport slave (
        output rd_valid, rd_data, wr_ready,
        input  rd_req, wr_valid, wr_data
    );
endinterface

// File: rtl/node_exec_ctrl_sat_counter.sv
// Tick-gated up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count qualified ticks, holding once the maximum is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (tick && inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_r;

endmodule

// File: rtl/node_exec_ctrl.sv
// Per-node execution sequencer: issues step_en, stalls on blocking neighbour
// reads/writes and keeps executed/stalled cycle counters.
module node_exec_ctrl
    import node_exec_ctrl_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [3:0]        op,
    input  logic [2:0]        src,
    input  logic [2:0]        dst,
    input  logic [DATA_W-1:0] src_data,
    node_exec_ctrl_if.master  port,
    output logic [DATA_W-1:0] port_operand,
    output logic              use_port_operand,
    output logic              step_en,
    output logic              stalled,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    exec_state_e       state_r, state_s;
    logic [3:0]        rd_req_r, rd_req_s;
    logic [3:0]        wr_valid_r, wr_valid_s;
    logic [DATA_W-1:0] wr_data_r, wr_data_s;
    logic [DATA_W-1:0] port_operand_r, port_operand_s;
    logic              use_port_r, use_port_s;
    logic              stalled_r, stalled_s;
    logic [1:0]        src_dir_r, src_dir_s;
    logic [1:0]        dst_dir_r, dst_dir_s;
    logic              mov_wr_r, mov_wr_s;
    logic              fwd_r, fwd_s;
    logic              step_s;
    logic [DATA_W-1:0] lane_s;

    assign lane_s = port.rd_data[int'(src_dir_r) * DATA_W +: DATA_W];

    // Next-state, next-register and step pulse decode; nothing moves without tick.
    always_comb begin
        state_s        = state_r;
        rd_req_s       = rd_req_r;
        wr_valid_s     = wr_valid_r;
        wr_data_s      = wr_data_r;
        port_operand_s = port_operand_r;
        use_port_s     = use_port_r;
        src_dir_s      = src_dir_r;
        dst_dir_s      = dst_dir_r;
        mov_wr_s       = mov_wr_r;
        fwd_s          = fwd_r;
        step_s         = 1'b0;
        if (tick) begin
            case (state_r)
                ST_EXEC: begin
                    if (use_port_r) begin
                        // Step cycle of an instruction whose operand came from a port.
                        step_s     = 1'b1;
                        use_port_s = 1'b0;
                    end else if (op_reads_port(op, src)) begin
                        state_s   = ST_READ;
                        src_dir_s = loc_dir(src);
                        dst_dir_s = loc_dir(dst);
                        mov_wr_s  = op_writes_port(op, dst);
                        rd_req_s  = dir_onehot(loc_dir(src));
                    end else if (op_writes_port(op, dst)) begin
                        state_s    = ST_WRITE;
                        dst_dir_s  = loc_dir(dst);
                        wr_data_s  = src_data;
                        wr_valid_s = dir_onehot(loc_dir(dst));
                    end else begin
                        step_s = 1'b1;
                    end
                end
                ST_READ: begin
                    if (fwd_r) begin
                        // Extra cycle moves the latched operand onto the write bus.
                        state_s    = ST_WRITE;
                        fwd_s      = 1'b0;
                        wr_data_s  = port_operand_r;
                        wr_valid_s = dir_onehot(dst_dir_r);
                    end else if (port.rd_valid[src_dir_r]) begin
                        port_operand_s = lane_s;
                        rd_req_s       = 4'b0000;
                        if (mov_wr_r) begin
                            fwd_s = 1'b1;
                        end else begin
                            state_s    = ST_EXEC;
                            use_port_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (port.wr_ready[dst_dir_r]) begin
                        step_s     = 1'b1;
                        wr_valid_s = 4'b0000;
                        state_s    = ST_EXEC;
                    end else begin
                        state_s = ST_WRITE;
                    end
                end
                default: begin
                    state_s    = ST_EXEC;
                    rd_req_s   = 4'b0000;
                    wr_valid_s = 4'b0000;
                    use_port_s = 1'b0;
                    fwd_s      = 1'b0;
                end
            endcase
        end else begin
            step_s = 1'b0;
        end
        stalled_s = (state_s != ST_EXEC);
    end

    // State and registered outputs; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_EXEC;
            rd_req_r       <= 4'b0000;
            wr_valid_r     <= 4'b0000;
            wr_data_r      <= {DATA_W{1'b0}};
            port_operand_r <= {DATA_W{1'b0}};
            use_port_r     <= 1'b0;
            stalled_r      <= 1'b0;
            src_dir_r      <= 2'd0;
            dst_dir_r      <= 2'd0;
            mov_wr_r       <= 1'b0;
            fwd_r          <= 1'b0;
        end else begin
            state_r        <= state_s;
            rd_req_r       <= rd_req_s;
            wr_valid_r     <= wr_valid_s;
            wr_data_r      <= wr_data_s;
            port_operand_r <= port_operand_s;
            use_port_r     <= use_port_s;
            stalled_r      <= stalled_s;
            src_dir_r      <= src_dir_s;
            dst_dir_r      <= dst_dir_s;
            mov_wr_r       <= mov_wr_s;
            fwd_r          <= fwd_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (reset),
        .tick  (tick),
        .inc   (1'b1),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .tick  (tick),
        .inc   (stalled_r),
        .count (stall_cnt)
    );

    assign port.rd_req       = rd_req_r;
    assign port.wr_valid     = wr_valid_r;
    assign port.wr_data      = wr_data_r;
    assign port_operand      = port_operand_r;
    assign use_port_operand  = use_port_r;
    assign stalled           = stalled_r;
    assign step_en           = step_s & reset;

endmodule

// File: tb/tb_node_exec_ctrl.sv
// Randomized bench for node_exec_ctrl: per-instruction timing model derived
// from the latency rules, with reactive neighbour stubs and counter model.
module tb_node_exec_ctrl;
    import node_exec_ctrl_pkg::*;

    localparam int DW   = 11;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          tick;
    logic [3:0]    op;
    logic [2:0]    src;
    logic [2:0]    dst;
    logic [DW-1:0] src_data;
    logic [DW-1:0] port_operand;
    logic          use_port_operand;
    logic          step_en;
    logic          stalled;
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] stall_cnt;

    int n_checks;
    int n_errors;
    int m_cycle;
    int m_stall;

    node_exec_ctrl_if #(.DATA_W(DW)) nif ();

    node_exec_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .tick             (tick),
        .op               (op),
        .src              (src),
        .dst              (dst),
        .src_data         (src_data),
        .port             (nif.master),
        .port_operand     (port_operand),
        .use_port_operand (use_port_operand),
        .step_en          (step_en),
        .stalled          (stalled),
        .cycle_cnt        (cycle_cnt),
        .stall_cnt        (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int dir);
        logic [3:0] one;
        one = 4'b0001;
        return one << dir;
    endfunction

    function automatic int rand_word();
        return int'($urandom_range(0, 1998)) - 999;
    endfunction

    // One instruction: drive it, play neighbour, check every tick against the latency rules.
    task automatic run_instr(input logic [3:0] i_op, input logic [2:0] i_src, input logic [2:0] i_dst,
                             input logic [DW-1:0] i_data, input logic [DW-1:0] i_lane,
                             input int w_r, input int w_w, input bit dense);
        bit reads, writes, done, st_k;
        int rdir, wdir, rd_end, wr_start, wr_end, stall_end, exp_ticks;
        int k, req_seen, wv_seen, budget;
        logic [3:0] e_rd, e_wr;
        logic [DW-1:0] e_wdata;
        reads  = ((i_op == OP_MOV) || (i_op == OP_ADD) || (i_op == OP_SUB) || (i_op == OP_JRO))
                 && (i_src >= 3'd2) && (i_src <= 3'd5);
        writes = (i_op == OP_MOV) && (i_dst >= 3'd2) && (i_dst <= 3'd5);
        rdir = int'(i_src) - 2;
        wdir = int'(i_dst) - 2;
        rd_end    = reads ? 2 + w_r : 1;
        wr_start  = reads ? rd_end + 2 : 2;
        wr_end    = writes ? wr_start + w_w : rd_end;
        exp_ticks = writes ? wr_end : (reads ? rd_end + 1 : 1);
        stall_end = writes ? wr_end : (reads ? rd_end : 1);
        e_wdata   = reads ? i_lane : i_data;
        k = 0; done = 1'b0; req_seen = 0; wv_seen = 0; budget = 0;
        while (!done && budget < 400) begin
            @(negedge clk);
            budget++;
            tick = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
            if ((k + 1) >= 2 && (k + 1) <= stall_end) begin
                op = 4'($urandom); src = 3'($urandom); dst = 3'($urandom);
                src_data = DW'($urandom);
            end else begin
                op = i_op; src = i_src; dst = i_dst; src_data = i_data;
            end
            for (int l = 0; l < 4; l++) nif.rd_data[l*DW +: DW] = DW'($urandom);
            nif.rd_valid = 4'($urandom);
            nif.wr_ready = 4'($urandom);
            if (reads && tick) begin
                nif.rd_valid[rdir] = (req_seen >= w_r);
                if (req_seen >= w_r) nif.rd_data[rdir*DW +: DW] = i_lane;
            end
            if (writes && tick) nif.wr_ready[wdir] = (wv_seen >= w_w);
            #3;
            if (tick) begin
                k++;
                st_k = (k >= 2) && (k <= stall_end);
                e_rd = (reads && k >= 2 && k <= rd_end) ? onehot(rdir) : 4'b0000;
                e_wr = (writes && k >= wr_start && k <= wr_end) ? onehot(wdir) : 4'b0000;
                check_eq("step_en", 32'(step_en), 32'(k == exp_ticks));
                check_eq("use_port_operand", 32'(use_port_operand), 32'(reads && !writes && k == exp_ticks));
                check_eq("rd_req", 32'(nif.rd_req), 32'(e_rd));
                check_eq("wr_valid", 32'(nif.wr_valid), 32'(e_wr));
                check_eq("stalled", 32'(stalled), 32'(st_k));
                if (e_wr != 4'b0000) check_eq("wr_data", 32'(nif.wr_data), 32'(e_wdata));
                if (reads && k == exp_ticks) check_eq("port_operand", 32'(port_operand), 32'(i_lane));
                if (reads && nif.rd_req[rdir]) req_seen++;
                if (writes && nif.wr_valid[wdir]) wv_seen++;
                if (m_cycle < CMAX) m_cycle++;
                if (st_k && m_stall < CMAX) m_stall++;
                if (k == exp_ticks) done = 1'b1;
            end else begin
                check_eq("step_en_notick", 32'(step_en), 32'd0);
            end
        end
        check_eq("instr_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check_eq("cycle_cnt", 32'(cycle_cnt), 32'(m_cycle));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check_eq("use_port_after", 32'(use_port_operand), 32'd0);
    endtask

    task automatic run_random(input int count);
        logic [3:0] r_op;
        for (int n = 0; n < count; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    r_op = OP_MOV;
                2:       r_op = OP_ADD;
                3:       r_op = OP_SUB;
                4:       r_op = OP_JRO;
                default: r_op = 4'($urandom_range(0, 12));
            endcase
            run_instr(r_op, 3'($urandom), 3'($urandom), DW'(rand_word()), DW'(rand_word()),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; m_cycle = 0; m_stall = 0;
        reset = 1'b0; tick = 1'b1; op = OP_ADD; src = LOC_ACC; dst = LOC_NIL; src_data = '0;
        nif.rd_valid = 4'b0000; nif.rd_data = '0; nif.wr_ready = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_step_en", 32'(step_en), 32'd0);
        check_eq("rst_rd_req", 32'(nif.rd_req), 32'd0);
        check_eq("rst_wr_valid", 32'(nif.wr_valid), 32'd0);
        check_eq("rst_wr_data", 32'(nif.wr_data), 32'd0);
        check_eq("rst_port_operand", 32'(port_operand), 32'd0);
        check_eq("rst_use_port", 32'(use_port_operand), 32'd0);
        check_eq("rst_stalled", 32'(stalled), 32'd0);
        check_eq("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b1; tick = 1'b0;

        run_instr(OP_ADD, LOC_ACC, LOC_NIL, DW'(5), DW'(0), 0, 0, 1'b1);
        run_instr(OP_MOV, LOC_UP, LOC_ACC, DW'(0), DW'(-42), 5, 0, 1'b1);
        check_eq("read_stall_cnt", 32'(stall_cnt), 32'd6);
        run_instr(OP_MOV, LOC_ACC, LOC_RIGHT, DW'(999), DW'(0), 0, 3, 1'b1);
        run_instr(OP_MOV, LOC_LEFT, LOC_DOWN, DW'(0), DW'(7), 0, 0, 1'b1);
        run_random(60);

        // Reset asserted between edges while a write is pending.
        @(negedge clk);
        tick = 1'b1; op = OP_MOV; src = LOC_ACC; dst = LOC_RIGHT; src_data = DW'(999);
        nif.rd_valid = 4'b0000; nif.wr_ready = 4'b0000;
        @(negedge clk);
        check_eq("pre_rst_wr_valid", 32'(nif.wr_valid), 32'(4'b1000));
        check_eq("pre_rst_wr_data", 32'(nif.wr_data), 32'(DW'(999)));
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_wr_valid", 32'(nif.wr_valid), 32'd0);
        check_eq("async_stalled", 32'(stalled), 32'd0);
        check_eq("async_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("async_cycle_cnt", 32'(cycle_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1; tick = 1'b0;
        m_cycle = 0; m_stall = 0;
        run_random(15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finish", n_checks);
        $fatal(1);
    end

endmodule
